// File: rtl/param_piso_serializer.sv
// Purpose: parallel-in serial-out shifter; one accepted word becomes WIDTH serial bits.
// Latency: first bit appears on out one cycle after the accepting edge.
// Backpressure: ready is high in IDLE, or on the last bit when shift_en=1; shift_en=0 stalls.
module param_piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             shift_en,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             at_last;
    logic             head_bit;

    assign at_last  = (cnt == CNT_LAST);
    assign head_bit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

    // Handshake and serial outputs decoded directly from the registered state.
    assign ready     = (state == IDLE) || (at_last && shift_en);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == SHIFT);
    assign last      = (state == SHIFT) && at_last;
    assign out       = (state == SHIFT) ? head_bit : IDLE_LEVEL;

    // Control FSM, bit counter and shift register; a stalled SHIFT holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sreg  <= in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (!at_last) begin
                            if (MSB_FIRST != 0) begin
                                sreg <= {sreg[WIDTH-2:0], 1'b0};
                            end else begin
                                sreg <= {1'b0, sreg[WIDTH-1:1]};
                            end
                            cnt <= cnt + CW'(1);
                        end else if (load) begin
                            // Back-to-back word: the next word's first bit follows with no gap.
                            sreg  <= in;
                            cnt   <= '0;
                            state <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_piso_serializer.sv
// Purpose: directed checks of the serializer at WIDTH=8 MSB-first and WIDTH=4 LSB-first.
// Latency: vectors are applied one per clock and outputs compared mid-cycle.
// Backpressure: stalls, dropped loads and back-to-back reloads are all exercised.
module tb_param_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in8;
    logic       load8, se8;
    logic       ready8, out8, valid8, last8, busy8;
    logic [3:0] in4;
    logic       load4, se4;
    logic       ready4, out4, valid4, last4, busy4;

    int nchk;
    int nerr;

    param_piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .load(load8), .shift_en(se8),
        .ready(ready8), .out(out8), .out_valid(valid8), .last(last8), .busy(busy8)
    );

    param_piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .load(load4), .shift_en(se4),
        .ready(ready4), .out(out4), .out_valid(valid4), .last(last4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each record: inputs for one cycle plus the outputs expected during that cycle.
    typedef struct {
        logic       rst;
        logic       ld;
        logic       se;
        logic [7:0] d;
        logic       eo;
        logic       ev;
        logic       el;
        logic       eb;
        logic       er;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic rst, input logic ld, input logic se, input logic [7:0] d,
                     input logic eo, input logic ev, input logic el, input logic eb,
                     input logic er);
        vec_t x;
        x.rst = rst; x.ld = ld; x.se = se; x.d = d;
        x.eo = eo; x.ev = ev; x.el = el; x.eb = eb; x.er = er;
        vq.push_back(x);
    endtask

    // Bits first..first+n-1 of an MSB-first word, shift_en=1, no load.
    task automatic run(input logic [7:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            v(1'b1, 1'b0, 1'b1, 8'h00, w[7-i], 1'b1, i == 7, 1'b1, i == 7);
        end
    endtask

    task automatic idle8(input logic se);
        v(1'b1, 1'b0, se, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load_w(input logic [7:0] w);
        v(1'b1, 1'b1, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   nvalid;
        int   nlast;
        int   lastpos;
        logic [3:0] got;

        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        in8 = 8'h00; load8 = 1'b0; se8 = 1'b0;
        in4 = 4'h0;  load4 = 1'b0; se4 = 1'b0;

        // Plain 8'hA5 word, then IDLE with shift_en ignored.
        load_w(8'hA5); run(8'hA5, 0, 8); idle8(1'b0);
        // Stall for three cycles at cnt==2, with a dropped load in the middle.
        load_w(8'hA5); run(8'hA5, 0, 2);
        v(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        v(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        v(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run(8'hA5, 2, 6); idle8(1'b1);
        // Back-to-back A5 then 3C, reloaded on the last-bit cycle.
        load_w(8'hA5); run(8'hA5, 0, 7);
        v(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        run(8'h3C, 0, 8); idle8(1'b1);
        // Load while busy is dropped; A5 completes unchanged.
        load_w(8'hA5); run(8'hA5, 0, 2);
        v(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run(8'hA5, 3, 5); idle8(1'b1);
        // Stall on the last bit: ready stays low and the load is ignored.
        load_w(8'h81); run(8'h81, 0, 7);
        v(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        v(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle8(1'b1);
        // Reset at cnt==4 beats a simultaneous load; the word is abandoned.
        load_w(8'hA5); run(8'hA5, 0, 4);
        v(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle8(1'b1); idle8(1'b1);
        // Reset while IDLE also beats load.
        v(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 0, 0, 0, 1'b1);
        idle8(1'b1);

        // Initial reset and reset-state check.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset out", out8, 1'b0);
        chk("reset out_valid", valid8, 1'b0);
        chk("reset last", last8, 1'b0);
        chk("reset busy", busy8, 1'b0);
        chk("reset ready", ready8, 1'b1);
        chk("reset4 out idle level", out4, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n = vq[i].rst;
            load8 = vq[i].ld;
            se8   = vq[i].se;
            in8   = vq[i].d;
            #1;
            chk($sformatf("vec%0d out", i),       out8,   vq[i].eo);
            chk($sformatf("vec%0d out_valid", i), valid8, vq[i].ev);
            chk($sformatf("vec%0d last", i),      last8,  vq[i].el);
            chk($sformatf("vec%0d busy", i),      busy8,  vq[i].eb);
            chk($sformatf("vec%0d ready", i),     ready8, vq[i].er);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; load8 = 1'b0; se8 = 1'b0;

        // WIDTH=4 LSB-first: 4'b1010 must come out as 0,1,0,1 in exactly four valid cycles.
        load4 = 1'b1; in4 = 4'b1010; se4 = 1'b1;
        #1;
        chk("w4 idle out", out4, 1'b1);
        chk("w4 idle out_valid", valid4, 1'b0);
        chk("w4 idle ready", ready4, 1'b1);
        @(posedge clk); #1;
        load4 = 1'b0; in4 = 4'b1111;
        nvalid = 0; nlast = 0; lastpos = -1; got = 4'h0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (valid4) begin
                if (nvalid < 4) got[nvalid] = out4;
                if (last4) lastpos = nvalid;
                nvalid++;
            end
            if (last4) nlast++;
            @(posedge clk); #1;
        end
        chk("w4 valid count", nvalid, 4);
        chk("w4 bit sequence", got, 4'b1010);
        chk("w4 last count", nlast, 1);
        chk("w4 last position", lastpos, 3);
        chk("w4 end out idle level", out4, 1'b1);
        chk("w4 end ready", ready4, 1'b1);
        chk("w4 end busy", busy4, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
